// File: rtl/agc_stim_sequencer.sv
// agc_stim_sequencer: divides SIM_CLK down to the AGC master CLOCK and drives
// NCH independently timed stimulus lines (delay / width / period / idle
// polarity). A run is bounded by RUN_LEN or stopped early by abort.
module agc_stim_sequencer #(
  parameter int NCH      = 8,
  parameter int CNT_W    = 32,
  parameter int CLK_HALF = 12,
  parameter int CHS_W    = 5
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             clk_en,
  input  logic             cfg_we,
  input  logic [CHS_W-1:0] cfg_ch,
  input  logic [2:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             start,
  input  logic             abort,
  output logic             CLOCK,
  output logic [NCH-1:0]   stim,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  // Channel states
  // state     | meaning
  // CH_IDLE   | no run in progress or channel off; line at POL
  // CH_WAIT   | counting DELAY before the first active edge
  // CH_ACTIVE | line at ~POL, counting WIDTH
  // CH_HOLD   | periodic gap, counting PERIOD-WIDTH
  // CH_DONE   | one-shot finished; line at POL until the run ends
  typedef enum logic [2:0] {
    CH_IDLE   = 3'd0,
    CH_WAIT   = 3'd1,
    CH_ACTIVE = 3'd2,
    CH_HOLD   = 3'd3,
    CH_DONE   = 3'd4
  } ch_state_e;

  localparam int               DIV_W    = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  localparam logic [2:0] SEL_DELAY  = 3'd0;
  localparam logic [2:0] SEL_WIDTH  = 3'd1;
  localparam logic [2:0] SEL_PERIOD = 3'd2;
  localparam logic [2:0] SEL_MODE   = 3'd3;
  localparam logic [2:0] SEL_POL    = 3'd4;
  localparam logic [2:0] SEL_RUN    = 3'd5;

  logic [CNT_W-1:0] delay_q  [NCH];
  logic [CNT_W-1:0] width_q  [NCH];
  logic [CNT_W-1:0] period_q [NCH];
  logic [1:0]       mode_q   [NCH];
  logic [NCH-1:0]   pol_q, pol_d;
  logic [CNT_W-1:0] run_len_q;
  logic             cfg_err_q;

  logic [DIV_W-1:0] div_q;
  logic             clock_q;

  ch_state_e        st_q  [NCH];
  ch_state_e        st_d  [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic             busy_q, busy_d, done_q, done_d;
  logic [NCH-1:0]   stim_q, stim_d;

  logic sel_ok, ch_ok, wr_ok, run_end;

  // RUN_LEN is global, so the channel index only matters for per-channel fields.
  assign sel_ok = (cfg_sel <= SEL_RUN);
  assign ch_ok  = (cfg_sel == SEL_RUN) || (32'(cfg_ch) < 32'(NCH));
  assign wr_ok  = cfg_we && !busy_q && !start && sel_ok && ch_ok;

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + ONE;
  assign run_end   = busy_q && (run_len_q != '0) && (timer_inc == run_len_q);

  // Next POL is needed by the stim register so a POL write shows up on the same edge.
  always_comb begin
    pol_d = pol_q;
    for (int i = 0; i < NCH; i++) begin
      if (wr_ok && cfg_sel == SEL_POL && cfg_ch == CHS_W'(i)) pol_d[i] = cfg_data[0];
    end
  end

  // Configuration register file and write-rejection flag.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      for (int i = 0; i < NCH; i++) begin
        delay_q[i]  <= '0;
        width_q[i]  <= '0;
        period_q[i] <= '0;
        mode_q[i]   <= 2'd0;
      end
      pol_q     <= '0;
      run_len_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !wr_ok;
      pol_q     <= pol_d;
      if (wr_ok && cfg_sel == SEL_RUN) run_len_q <= cfg_data;
      for (int i = 0; i < NCH; i++) begin
        if (wr_ok && cfg_ch == CHS_W'(i)) begin
          case (cfg_sel)
            SEL_DELAY:  delay_q[i]  <= cfg_data;
            SEL_WIDTH:  width_q[i]  <= cfg_data;
            SEL_PERIOD: period_q[i] <= cfg_data;
            SEL_MODE:   mode_q[i]   <= cfg_data[1:0];
            default:    ;
          endcase
        end
      end
    end
  end

  // CLOCK divider; clk_en freezes both the count and the output level.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      div_q   <= '0;
      clock_q <= 1'b0;
    end else if (clk_en) begin
      if (div_q == DIV_LAST) begin
        div_q   <= '0;
        clock_q <= ~clock_q;
      end else begin
        div_q <= div_q + DIV_ONE;
      end
    end
  end

  // Run control and per-channel next state; abort has priority over run end.
  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    timer_d = timer_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    if (!busy_q) begin
      if (start) begin
        busy_d  = 1'b1;
        timer_d = '0;
        for (int i = 0; i < NCH; i++) begin
          if (mode_q[i] == 2'd1 || mode_q[i] == 2'd2) begin
            st_d[i]  = CH_WAIT;
            cnt_d[i] = delay_q[i];
          end
        end
      end
    end else if (abort || run_end) begin
      busy_d = 1'b0;
      done_d = !abort;
      for (int i = 0; i < NCH; i++) st_d[i] = CH_IDLE;
    end else begin
      timer_d = timer_inc;
      for (int i = 0; i < NCH; i++) begin
        case (st_q[i])
          CH_WAIT: begin
            if (cnt_q[i] == '0) begin
              if (width_q[i] != '0) begin
                st_d[i]  = CH_ACTIVE;
                cnt_d[i] = width_q[i] - ONE;
              end else if (mode_q[i] == 2'd2) begin
                st_d[i] = CH_HOLD;
              end else begin
                st_d[i] = CH_DONE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - ONE;
            end
          end
          CH_ACTIVE: begin
            if (cnt_q[i] == '0) begin
              // A period no longer than the width leaves no gap: stay active.
              if (mode_q[i] != 2'd2) begin
                st_d[i] = CH_DONE;
              end else if (period_q[i] > width_q[i]) begin
                st_d[i]  = CH_HOLD;
                cnt_d[i] = period_q[i] - width_q[i] - ONE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - ONE;
            end
          end
          CH_HOLD: begin
            // Zero-width periodic channels park here for the rest of the run.
            if (width_q[i] != '0) begin
              if (cnt_q[i] == '0) begin
                st_d[i]  = CH_ACTIVE;
                cnt_d[i] = width_q[i] - ONE;
              end else begin
                cnt_d[i] = cnt_q[i] - ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
    for (int i = 0; i < NCH; i++) begin
      stim_d[i] = (st_d[i] == CH_ACTIVE) ? ~pol_d[i] : pol_d[i];
    end
  end

  // Run/channel state registers with registered outputs.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      timer_q <= '0;
      stim_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= CH_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      timer_q <= timer_d;
      stim_q  <= stim_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end

  assign CLOCK   = clock_q;
  assign stim    = stim_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_agc_stim_sequencer.sv
// Testbench for agc_stim_sequencer: table vectors, hand sequences and
// randomized runs checked against a closed-form timing model.
module tb_agc_stim_sequencer;

  localparam int NCH      = 8;
  localparam int CNT_W    = 32;
  localparam int CLK_HALF = 12;
  localparam int CHS_W    = 5;

  logic             SIM_CLK = 1'b0;
  logic             SIM_RST = 1'b1;
  logic             clk_en  = 1'b1;
  logic             cfg_we  = 1'b0;
  logic [CHS_W-1:0] cfg_ch  = '0;
  logic [2:0]       cfg_sel = '0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic             start   = 1'b0;
  logic             abort   = 1'b0;
  logic             CLOCK;
  logic [NCH-1:0]   stim;
  logic             busy, done, cfg_err;

  agc_stim_sequencer #(.NCH(NCH), .CNT_W(CNT_W), .CLK_HALF(CLK_HALF), .CHS_W(CHS_W)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .clk_en(clk_en), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .start(start),
    .abort(abort), .CLOCK(CLOCK), .stim(stim), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Reference copy of the programmed configuration.
  int             m_delay  [NCH];
  int             m_width  [NCH];
  int             m_period [NCH];
  int             m_mode   [NCH];
  logic [NCH-1:0] m_pol;
  int             m_run_len;

  typedef struct {
    int   mode;
    int   pol;
    int   dly;
    int   wid;
    int   per;
    int   rlen;
    int   probe;
    logic exp_stim;
    logic exp_busy;
    logic exp_done;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_delay[c] = 0; m_width[c] = 0; m_period[c] = 0; m_mode[c] = 0;
    end
    m_pol     = '0;
    m_run_len = 0;
  endtask

  task automatic cfg_wr(input int ch, input int sel, input int data);
    cfg_we   = 1'b1;
    cfg_ch   = CHS_W'(ch);
    cfg_sel  = 3'(sel);
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
    case (sel)
      0: m_delay[ch]  = data;
      1: m_width[ch]  = data;
      2: m_period[ch] = data;
      3: m_mode[ch]   = data & 3;
      4: m_pol[ch]    = data[0];
      5: m_run_len    = data;
      default: ;
    endcase
  endtask

  // Is channel ch at its active level k cycles after the start edge (run still going)?
  function automatic logic exp_active(input int ch, input int k);
    int j;
    if (m_mode[ch] != 1 && m_mode[ch] != 2) return 1'b0;
    if (k < m_delay[ch] + 1) return 1'b0;
    if (m_width[ch] == 0) return 1'b0;
    j = k - (m_delay[ch] + 1);
    if (m_mode[ch] == 1) return (j < m_width[ch]);
    if (m_period[ch] <= m_width[ch]) return 1'b1;
    return ((j % m_period[ch]) < m_width[ch]);
  endfunction

  function automatic logic [NCH-1:0] exp_stim(input int k, input logic running);
    logic [NCH-1:0] v;
    v = m_pol;
    if (running) begin
      for (int c = 0; c < NCH; c++) if (exp_active(c, k)) v[c] = ~m_pol[c];
    end
    return v;
  endfunction

  // Start a run and compare every cycle against the model; abort_at is the
  // offset of the edge that samples abort (0 = no abort).
  task automatic run_check(input string name, input int abort_at, input int max_k);
    int   end_k, stop, last;
    logic done_ok, running, dexp;
    end_k = (m_run_len != 0) ? m_run_len : (1 << 30);
    if (abort_at > 0 && abort_at <= end_k) begin
      stop = abort_at; done_ok = 1'b0;
    end else begin
      stop = end_k; done_ok = (m_run_len != 0);
    end
    last = (stop + 2 < max_k) ? stop + 2 : max_k;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= last; k++) begin
      running = (k < stop);
      dexp    = (k == stop) && done_ok;
      check(name, 32'({stim, busy, done, cfg_err}), 32'({exp_stim(k, running), running, dexp, 1'b0}));
      if (k < last) begin
        if (k + 1 == abort_at) abort = 1'b1;
        tick();
        abort = 1'b0;
      end
    end
    if (busy) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n_clk;
    model_clear();

    // Reset state and CLOCK divider, including a clk_en freeze window.
    repeat (3) tick();
    check("reset_state", 32'({CLOCK, stim, busy, done, cfg_err}), 32'(0));
    SIM_RST = 1'b0;
    n_clk = 0;
    for (int i = 0; i < 70; i++) begin
      clk_en = !(i >= 30 && i < 37);
      tick();
      if (clk_en) n_clk++;
      check("clock", 32'(CLOCK), 32'((n_clk / CLK_HALF) % 2));
    end
    clk_en = 1'b1;

    // Single-channel probes on ch3: {mode,pol,dly,wid,per,rlen,probe,stim,busy,done}
    tbl[0]  = '{1, 0, 2, 3, 0, 0, 2, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1, 0, 2, 3, 0, 0, 3, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1, 0, 2, 3, 0, 0, 5, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1, 0, 2, 3, 0, 0, 6, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1, 0, 0, 1, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2, 0, 1, 5, 2, 0, 2, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{2, 0, 1, 5, 2, 0, 40, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{2, 0, 0, 2, 0, 0, 30, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{2, 1, 0, 2, 5, 0, 6, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{2, 1, 0, 2, 5, 0, 4, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{2, 0, 0, 0, 3, 0, 5, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{3, 1, 0, 5, 0, 0, 2, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1, 0, 0, 50, 0, 4, 4, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1, 0, 0, 50, 0, 4, 3, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{0, 1, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 17; i++) begin
      cfg_wr(3, 3, tbl[i].mode);
      cfg_wr(3, 4, tbl[i].pol);
      cfg_wr(3, 0, tbl[i].dly);
      cfg_wr(3, 1, tbl[i].wid);
      cfg_wr(3, 2, tbl[i].per);
      cfg_wr(0, 5, tbl[i].rlen);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < tbl[i].probe; k++) tick();
      check($sformatf("tbl%0d", i), 32'({stim[3], busy, done}),
            32'({tbl[i].exp_stim, tbl[i].exp_busy, tbl[i].exp_done}));
      if (busy) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      tick();
    end

    // ch0 one-shot with a long delay and a bounded run ending in done.
    cfg_wr(3, 3, 0);
    cfg_wr(0, 4, 0);
    cfg_wr(0, 0, 250);
    cfg_wr(0, 1, 25);
    cfg_wr(0, 3, 1);
    cfg_wr(0, 5, 2500);
    run_check("oneshot_ch0", 0, 2510);

    // ch1 periodic, inverted polarity, aborted mid-run.
    cfg_wr(0, 3, 0);
    cfg_wr(1, 4, 1);
    cfg_wr(1, 0, 0);
    cfg_wr(1, 1, 3);
    cfg_wr(1, 2, 10);
    cfg_wr(1, 3, 2);
    cfg_wr(0, 5, 0);
    run_check("periodic_abort_ch1", 26, 40);

    // Rejected writes: with start, while busy, bad channel, bad select.
    cfg_wr(1, 3, 0);
    cfg_wr(2, 3, 1);
    cfg_wr(2, 0, 1);
    cfg_wr(2, 1, 2);
    cfg_wr(2, 4, 0);
    cfg_wr(0, 5, 10);
    cfg_we = 1'b1; cfg_ch = 5'd2; cfg_sel = 3'd0; cfg_data = 32'd7; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check("err_start_we", 32'({cfg_err, busy}), 32'(2'b11));
    tick();
    check("err_once", 32'(cfg_err), 32'(0));
    cfg_we = 1'b1; cfg_ch = 5'd2; cfg_sel = 3'd1; cfg_data = 32'd9;
    tick();
    cfg_we = 1'b0;
    check("err_busy", 32'(cfg_err), 32'(1));
    for (int i = 0; i < 30 && busy; i++) tick();
    check("busy_drop_bound", 32'(busy), 32'(0));
    cfg_we = 1'b1; cfg_ch = CHS_W'(NCH); cfg_sel = 3'd0; cfg_data = 32'd7;
    tick();
    cfg_we = 1'b0;
    check("err_bad_ch", 32'(cfg_err), 32'(1));
    cfg_we = 1'b1; cfg_ch = '0; cfg_sel = 3'd6; cfg_data = 32'd3;
    tick();
    cfg_we = 1'b0;
    check("err_bad_sel", 32'(cfg_err), 32'(1));
    cfg_wr(5, 4, int'(m_pol[5]));
    check("no_err_valid", 32'(cfg_err), 32'(0));
    run_check("cfg_unchanged", 0, 20);

    // Randomized configurations and runs against the model.
    for (int r = 0; r < 15; r++) begin
      int rl, ab;
      for (int c = 0; c < NCH; c++) begin
        cfg_wr(c, 0, int'($urandom_range(0, 30)));
        cfg_wr(c, 1, int'($urandom_range(0, 10)));
        cfg_wr(c, 2, int'($urandom_range(0, 20)));
        cfg_wr(c, 3, int'($urandom_range(0, 3)));
        cfg_wr(c, 4, int'($urandom_range(0, 1)));
      end
      rl = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(20, 120));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 130)) : 0;
      if (rl == 0 && ab == 0) ab = int'($urandom_range(10, 100));
      cfg_wr(0, 5, rl);
      run_check($sformatf("rand%0d", r), ab, 200);
    end

    // Reset while ch0 is active clears outputs and configuration.
    cfg_wr(0, 4, 0);
    cfg_wr(0, 0, 2);
    cfg_wr(0, 1, 10);
    cfg_wr(0, 3, 1);
    cfg_wr(0, 5, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("rst_pre_active", 32'(stim[0]), 32'(1));
    SIM_RST = 1'b1;
    tick();
    check("rst_outputs", 32'({stim, busy, done, cfg_err}), 32'(0));
    SIM_RST = 1'b0;
    model_clear();
    tick();
    run_check("post_rst", 20, 25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
